mat_vec_mac: RTL
================

# mat_vec_mac

Sequential matrix-vector multiply-accumulate stage that consumes the flattened B vector produced by the matrix B loader. It streams rows of matrix A one 32-bit word per handshake and returns one signed dot product per A row through a valid/ready result port. There is one multiplier, and it completes one MAC per accepted A word.

## Interface
- `LEN`, 4, vector length (B elements per vector, A words per row); ≥2
- `ROWS`, 4, number of A rows per job; ≥2
- `DW`, 32, element width; signed two's complement
- `ACC_W`, `2*DW+$clog2(LEN)`, accumulator and result width (66 at defaults)

- `clk` in 1: single clock, rising edge
- `n_reset` in 1: asynchronous, active-low reset
- `start` in 1: job start request, sampled in IDLE only
- `b_busy` in 1: B loader busy flag; `start` is ignored while high
- `b_data` in `LEN*DW`: flattened B vector; element j occupies bits `[(j+1)*DW-1 -: DW]`
- `a_valid` in 1: A word valid
- `a_data` in `DW`: A word; row-major, element 0 first
- `a_ready` out 1: stage accepts A word
- `res_valid` out 1: result valid
- `res_data` out `ACC_W`: signed dot product
- `res_row` out `$clog2(ROWS)`: A row index of `res_data`
- `res_ready` in 1: consumer accepts result
- `busy` out 1: high whenever state ≠ IDLE
- `done` out 1: one-cycle pulse when the last row's result is accepted

## Operation
- **States:** IDLE, RUN, OUT.
- **IDLE:**
  - On `start && !b_busy`: latch `b_data` into internal `b_reg`, clear `acc`, set `idx=0`, `row=0`, and go to RUN.
  - `start` while `b_busy` is high is dropped, not queued.
- **RUN:**
  - `a_ready=1`.
  - On `a_valid && a_ready`: `acc <= acc + sext(a_data * b_reg[idx])`, where the product is a full 2*DW signed result sign-extended to ACC_W, and `idx <= idx+1`.
  - On the handshake with `idx==LEN-1`: `idx <= 0` and go to OUT. The last product is included in `acc`.
  - `a_valid` gaps stall the stage with no state change.
- **OUT:**
  - `a_ready=0`, `res_valid=1`, `res_data=acc`, `res_row=row`.
  - On `res_ready`:
    - If `row==ROWS-1`: pulse `done` and go to IDLE.
    - Otherwise: `row <= row+1`, `acc <= 0`, go to RUN.
- **B operand:** `b_reg` is held for the whole job. Changes on `b_data` after start have no effect.
- **`start` outside IDLE:** ignored.
- **Overflow:** none possible at ACC_W. The worst case is LEN·(−2^(DW−1))² = 2^64 at defaults, which fits a 66-bit signed value.
- **Reset (any state, including mid-row or mid-OUT):**
  - State returns to IDLE.
  - `acc`, `idx`, `row`, and `b_reg` are cleared.
  - All outputs go to 0 immediately.
  - A partial result is discarded and never presented.

## Timing
- **Reset values:** `a_ready=0`, `res_valid=0`, `res_data=0`, `res_row=0`, `busy=0`, `done=0`.
- **Start:** `start` sampled at edge T makes `busy=1` and `a_ready=1` from T+1.
- **A port:** `a_ready` decodes from registered state only, with no combinational path from `a_valid`. One word is accepted per cycle at most.
- **Result latency:** `res_valid` rises the cycle after the LEN-th A handshake. Minimum job length is ROWS·(LEN+1) cycles, which is 20 at defaults with `a_valid` and `res_ready` held high.
- **Result hold:** while `res_valid && !res_ready`, `res_data` and `res_row` are held stable.
- **Result transfer:** `res_valid` drops the cycle after the transfer edge.
- **Next row:** `a_ready` rises the cycle after a non-final result transfer.
- **`done`:** asserted for exactly the one cycle after the final transfer edge, in the same cycle `busy` goes low.
- **Back-to-back jobs:** a new `start` can be accepted in the cycle `done` is high.

## Test plan
1. **Basic job.** Stimulus: B={1,2,3,4}; A rows {1,1,1,1}, {0,0,0,1}, {2,0,0,0}, {-1,-1,-1,-1}; `res_ready=1`. Response: results 10, 4, 2, −10 with `res_row` 0..3, `done` one pulse, first `res_valid` 5 cycles after start acceptance, total 20 cycles.
2. **Signed extremes.** Stimulus: B and all A words = 0x80000000. Response: each result = 2^64 (66'h1_0000_0000_0000_0000, positive, no wrap).
3. **Backpressure and gaps.** Stimulus: `a_valid` toggling every other cycle; `res_ready` held low for 3 cycles in OUT. Response: sums are unchanged versus scenario 1, `res_data`/`res_row` are stable while stalled, and no A word is accepted during OUT.
4. **Blocked start.** Stimulus: `start` pulsed with `b_busy=1`. Response: `busy` stays 0. A second `start` with `b_busy=0` runs, and changing `b_data` mid-job does not affect the results.
5. **Reset mid-run.** Stimulus: assert `n_reset` low after 2 A words of row 1. Response: all outputs go to 0 asynchronously. After release with no `start`, `res_valid` is never asserted. A fresh job reproduces scenario 1.
6. **Start while busy.** Stimulus: `start` pulses during RUN and OUT. Response: ignored; the job completes with exactly 4 results and one `done`.

Source files
------------

// File: rtl/mat_vec_mac.sv
// mat_vec_mac: sequential matrix-vector multiply-accumulate stage.
//
// A job multiplies ROWS rows of matrix A (streamed one DW-bit word per
// handshake, row-major) by a LEN-element B vector captured from b_data when
// the job starts. Each row yields one signed dot product on the result port.
// One multiplier does one MAC per accepted A word.
//
// Ports:
//   clk        rising-edge clock
//   n_reset    asynchronous active-low reset
//   start      job start request (acted on in IDLE only, and only while !b_busy)
//   b_busy     B loader busy; a start seen while it is high is dropped
//   b_data     flattened B vector, element j at [(j+1)*DW-1 -: DW]
//   a_valid    A word valid
//   a_data     A word (signed)
//   a_ready    stage accepts an A word (RUN state only)
//   res_valid  dot product valid (OUT state only)
//   res_data   signed dot product, ACC_W bits
//   res_row    A row index of res_data
//   res_ready  consumer accepts the result
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle pulse after the final row's result is taken
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 OUT)
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. The stage's ready/valid outputs decode from
// registered state only, so they never depend combinationally on the peer's
// valid/ready input. While res_valid is high and res_ready is low, res_data
// and res_row are held stable.

module mat_vec_mac #(
  parameter int LEN   = 4,
  parameter int ROWS  = 4,
  parameter int DW    = 32,
  parameter int ACC_W = 2*DW + $clog2(LEN)
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic                     b_busy,
  input  logic [LEN*DW-1:0]        b_data,
  input  logic                     a_valid,
  input  logic [DW-1:0]            a_data,
  output logic                     a_ready,
  output logic                     res_valid,
  output logic [ACC_W-1:0]         res_data,
  output logic [$clog2(ROWS)-1:0]  res_row,
  input  logic                     res_ready,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  localparam int IDX_W = $clog2(LEN);
  localparam int ROW_W = $clog2(ROWS);
  localparam int PW    = 2*DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ROW_W-1:0]   row_q;
  logic [DW-1:0]      b_mem [LEN];
  logic               done_q;

  logic               start_ok;
  logic               a_fire;
  logic               res_fire;
  logic               last_word;
  logic               last_row;
  logic [PW-1:0]      a_ext;
  logic [PW-1:0]      b_ext;
  logic [PW-1:0]      prod;
  logic [ACC_W-1:0]   prod_ext;

  assign start_ok  = start && !b_busy;
  assign a_fire    = a_valid && a_ready;
  assign res_fire  = res_valid && res_ready;
  assign last_word = (idx_q == IDX_W'(LEN-1));
  assign last_row  = (row_q == ROW_W'(ROWS-1));

  // Both operands are sign-extended to 2*DW, so the low 2*DW bits of the
  // product are the exact signed product; it is then widened to ACC_W.
  assign a_ext    = {{DW{a_data[DW-1]}}, a_data};
  assign b_ext    = {{DW{b_mem[idx_q][DW-1]}}, b_mem[idx_q]};
  assign prod     = $signed(a_ext) * $signed(b_ext);
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = RUN;
      RUN:  if (a_fire && last_word) state_d = OUT;
      OUT:  if (res_fire) state_d = last_row ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  // Output decode (registered state only)
  always_comb begin
    a_ready   = (state_q == RUN);
    res_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
    res_data  = acc_q;
    res_row   = row_q;
    done      = done_q;
    state_dbg = state_q;
  end

  // Datapath: B capture, accumulator, word and row counters, done pulse
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc_q  <= '0;
      idx_q  <= '0;
      row_q  <= '0;
      done_q <= 1'b0;
      for (int j = 0; j < LEN; j++) begin
        b_mem[j] <= '0;
      end
    end else begin
      done_q <= (state_q == OUT) && res_fire && last_row;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            for (int j = 0; j < LEN; j++) begin
              b_mem[j] <= b_data[j*DW +: DW];
            end
            acc_q <= '0;
            idx_q <= '0;
            row_q <= '0;
          end
        end
        RUN: begin
          if (a_fire) begin
            acc_q <= acc_q + prod_ext;
            idx_q <= last_word ? '0 : idx_q + IDX_W'(1);
          end
        end
        OUT: begin
          // The final row keeps acc/row until the next start clears them.
          if (res_fire && !last_row) begin
            row_q <= row_q + ROW_W'(1);
            acc_q <= '0;
          end
        end
        default: begin
          acc_q <= '0;
        end
      endcase
    end
  end

endmodule
